// File: rtl/i2c_master_ctrl.sv
// I2C master: multi-byte write/read transactions with a programmable SCL rate,
// open-drain pin control, real ACK sampling and valid/ready byte streams.
module i2c_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int CLK_DIV    = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  ready,
    output logic                  done,
    output logic                  nack,
    output logic                  scl_o,
    output logic                  sda_o,
    input  logic                  sda_i
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int BW = $clog2(SW + 1);
    localparam logic [QW-1:0] QLAST      = QW'(CLK_DIV - 1);
    localparam logic [BW-1:0] ABITS_LAST = BW'(ADDR_WIDTH);
    localparam logic [BW-1:0] DBITS_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_WAIT_TX,
        S_WRITE, S_ACK_W, S_READ, S_MACK, S_STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [QW-1:0]         qcnt_reg, qcnt_next;
    logic [1:0]            q_reg, q_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic [SW-1:0]         shift_reg, shift_next;
    logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
    logic                  rw_reg, rw_next;
    logic                  nack_reg, nack_next;
    logic                  samp_reg, samp_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic                  rx_valid_reg, rx_valid_next;

    logic quarter_end, bit_end, sample_now, timing_run, want_tx;

    assign quarter_end = (qcnt_reg == QLAST);
    assign bit_end     = quarter_end && (q_reg == 2'd3);
    assign sample_now  = quarter_end && (q_reg == 2'd2);
    assign timing_run  = (state_reg != S_IDLE) && (state_reg != S_WAIT_TX);
    // After a good ACK on a write with bytes left, the next byte may be taken
    // right at the ACK bit boundary so an unstalled stream costs no extra cycles.
    assign want_tx     = !samp_reg && !rw_reg && (rem_reg != '0);

    assign ready    = (state_reg == S_IDLE);
    assign nack     = nack_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg    <= S_IDLE;
            qcnt_reg     <= '0;
            q_reg        <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            rem_reg      <= '0;
            rw_reg       <= 1'b0;
            nack_reg     <= 1'b0;
            samp_reg     <= 1'b1;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            qcnt_reg     <= qcnt_next;
            q_reg        <= q_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            rem_reg      <= rem_next;
            rw_reg       <= rw_next;
            nack_reg     <= nack_next;
            samp_reg     <= samp_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        qcnt_next     = qcnt_reg;
        q_next        = q_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        rem_next      = rem_reg;
        rw_next       = rw_reg;
        nack_next     = nack_reg;
        samp_next     = samp_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        scl_o         = 1'b1;
        sda_o         = 1'b1;
        tx_ready      = 1'b0;
        done          = 1'b0;

        if (timing_run) begin
            if (quarter_end) begin
                qcnt_next = '0;
                q_next    = q_reg + 2'd1;
            end else begin
                qcnt_next = qcnt_reg + QW'(1);
            end
        end else begin
            qcnt_next = '0;
            q_next    = '0;
        end

        if (sample_now) begin
            samp_next = sda_i;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_START;
                    rw_next    = rw;
                    rem_next   = len;
                    nack_next  = 1'b0;
                    shift_next = SW'({addr, rw}) << (SW - ADDR_WIDTH - 1);
                end
            end
            S_START: begin
                sda_o = !q_reg[1];
                if (bit_end) begin
                    state_next = S_ADDR;
                    bit_next   = '0;
                end
            end
            S_ADDR: begin
                scl_o = q_reg[1];
                sda_o = shift_reg[SW-1];
                if (bit_end) begin
                    shift_next = shift_reg << 1;
                    if (bit_reg == ABITS_LAST) begin
                        state_next = S_ACK_A;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            S_ACK_A, S_ACK_W: begin
                scl_o = q_reg[1];
                if (bit_end) begin
                    if (samp_reg) begin
                        nack_next  = 1'b1;
                        state_next = S_STOP;
                    end else if (rem_reg == '0) begin
                        state_next = S_STOP;
                    end else if (rw_reg) begin
                        state_next = S_READ;
                        bit_next   = '0;
                    end else begin
                        tx_ready = want_tx;
                        if (tx_valid) begin
                            state_next = S_WRITE;
                            bit_next   = '0;
                            shift_next = SW'(tx_data) << (SW - DATA_WIDTH);
                        end else begin
                            state_next = S_WAIT_TX;
                        end
                    end
                end
            end
            S_WAIT_TX: begin
                scl_o    = 1'b0;
                tx_ready = 1'b1;
                if (tx_valid) begin
                    state_next = S_WRITE;
                    bit_next   = '0;
                    shift_next = SW'(tx_data) << (SW - DATA_WIDTH);
                end
            end
            S_WRITE: begin
                scl_o = q_reg[1];
                sda_o = shift_reg[SW-1];
                if (bit_end) begin
                    shift_next = shift_reg << 1;
                    if (bit_reg == DBITS_LAST) begin
                        rem_next   = rem_reg - LEN_WIDTH'(1);
                        state_next = S_ACK_W;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            S_READ: begin
                scl_o = q_reg[1];
                if (sample_now) begin
                    shift_next = {shift_reg[SW-2:0], sda_i};
                end
                if (bit_end) begin
                    if (bit_reg == DBITS_LAST) begin
                        rx_data_next  = shift_reg[DATA_WIDTH-1:0];
                        rx_valid_next = 1'b1;
                        rem_next      = rem_reg - LEN_WIDTH'(1);
                        state_next    = S_MACK;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            S_MACK: begin
                // ACK keeps the slave sending; NACK on the final byte lets it release.
                scl_o = q_reg[1];
                sda_o = (rem_reg == '0);
                if (bit_end) begin
                    if (rem_reg != '0) begin
                        state_next = S_READ;
                        bit_next   = '0;
                    end else begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                scl_o = (q_reg != 2'd0);
                sda_o = q_reg[1];
                if (bit_end) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a transaction table run against a bit-level
// slave model, plus hand-written busy-start and mid-transfer reset sequences.
module tb_i2c_master_ctrl;
    logic       clk = 1'b0;
    logic       arst_n, start, rw, tx_valid, sda_i;
    logic [6:0] addr;
    logic [3:0] len;
    logic [7:0] tx_data, rx_data;
    logic       tx_ready, rx_valid, ready, done, nack, scl_o, sda_o;

    int checks = 0;
    int errors = 0;

    i2c_master_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CLK_DIV(4), .LEN_WIDTH(4)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .rw(rw), .addr(addr), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .ready(ready), .done(done),
        .nack(nack), .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    // Slave model: wired-AND bus, bits captured on SCL rising edges.
    logic       slave_sda = 1'b1;
    logic       prev_scl = 1'b1, prev_bus = 1'b1;
    logic       bus_bits [0:255];
    int         nbits = 0, n_start = 0, n_stop = 0;
    logic [3:0] cur_len;
    logic [31:0] cur_data;
    logic       cur_ack_addr;
    logic [3:0] cur_ack_data;

    assign sda_i = sda_o & slave_sda;

    function automatic logic slave_bit(input int r);
        int b, j;
        if (r < 8) return 1'b1;
        if (r == 8) return cur_ack_addr;
        if (cur_ack_addr) return 1'b1;
        b = (r - 9) / 9;
        j = (r - 9) % 9;
        if (b >= int'(cur_len)) return 1'b1;
        if (bus_bits[7] == 1'b0) return (j == 8) ? cur_ack_data[b % 4] : 1'b1;
        return (j == 8) ? 1'b1 : cur_data[8 * (b % 4) + 7 - j];
    endfunction

    always @(negedge clk) begin
        logic bus;
        bus = sda_o & slave_sda;
        if (!arst_n) begin
            slave_sda = 1'b1;
        end else begin
            if (prev_scl && scl_o && prev_bus && !bus) begin
                n_start = n_start + 1;
                nbits   = 0;
            end else if (prev_scl && scl_o && !prev_bus && bus) begin
                n_stop = n_stop + 1;
            end
            if (!prev_scl && scl_o) begin
                if (nbits < 256) bus_bits[nbits] = bus;
                nbits = nbits + 1;
            end
            if (prev_scl && !scl_o) slave_sda = slave_bit(nbits);
        end
        prev_scl = scl_o;
        prev_bus = sda_o & slave_sda;
    end

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [3:0]  len;
        logic [31:0] data;       // byte b uses data[8*(b%4) +: 8]
        logic        ack_addr;   // 1 = slave NACKs the address
        logic [3:0]  ack_data;   // per write byte (b%4): 1 = slave NACKs
        int          gap;        // tx_valid withheld this many cycles before byte 1
        int          busy_at;    // cycle to pulse a second start (0 = none)
        int          exp_cycles;
        logic        exp_nack;
        int          exp_bytes;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n, ntook, nrx, tx_idx, stall_cnt, s0, p0, moved;
        logic took, stall_bad, saw_txr, got_done, idle_bad;
        logic [7:0] rx_log [16];
        logic [7:0] abyte, dbyte;
        cur_len = v.len; cur_data = v.data;
        cur_ack_addr = v.ack_addr; cur_ack_data = v.ack_data;
        ntook = 0; nrx = 0; tx_idx = 0; stall_cnt = 0;
        took = 1'b0; stall_bad = 1'b0; saw_txr = 1'b0; got_done = 1'b0;
        s0 = n_start; p0 = n_stop;
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        rw = v.rw; addr = v.addr; len = v.len; start = 1'b1;
        tx_data = v.data[7:0];
        tx_valid = !v.rw && (v.len != 0);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!got_done && n < 6000) begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) chk("nack_cleared", nack, 0);
            if (v.busy_at != 0 && n == v.busy_at) begin
                chk("busy_not_ready", ready, 0);
                start = 1'b1; rw = 1'b1; addr = 7'h11; len = 4'd3;
            end else if (v.busy_at != 0 && n == v.busy_at + 1) begin
                start = 1'b0;
            end
            if (took) begin
                ntook = ntook + 1;
                tx_idx = tx_idx + 1;
                if (tx_idx < int'(v.len)) begin
                    tx_data = v.data[8 * (tx_idx % 4) +: 8];
                    tx_valid = !(tx_idx == 1 && v.gap > 0);
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (tx_idx == 1 && v.gap > 0 && !tx_valid && tx_idx < int'(v.len)) begin
                if (tx_ready) begin
                    stall_cnt = stall_cnt + 1;
                    if (stall_cnt > 1 && scl_o !== 1'b0) stall_bad = 1'b1;
                    if (stall_cnt == v.gap) tx_valid = 1'b1;
                end else if (stall_cnt > 0) begin
                    stall_bad = 1'b1;
                end
            end
            if (tx_ready) saw_txr = 1'b1;
            took = tx_valid && tx_ready;
            if (rx_valid) begin
                if (nrx < 16) rx_log[nrx] = rx_data;
                nrx = nrx + 1;
            end
            if (done) got_done = 1'b1;
        end
        chk("done_cycles", n, v.exp_cycles);
        chk("nack_at_done", nack, v.exp_nack);
        @(negedge clk);
        chk("done_pulse_ready", {done, ready}, 2'b01);
        chk("start_stop_count", {n_start - s0, n_stop - p0}, {32'd1, 32'd1});
        abyte = '0;
        for (int k = 0; k < 8; k++) abyte = {abyte[6:0], bus_bits[k]};
        chk("addr_byte", abyte, {v.addr, v.rw});
        moved = v.rw ? nrx : ntook;
        chk("bytes_moved", moved, v.exp_bytes);
        if (!v.rw && v.exp_bytes == 0) chk("no_tx_ready", saw_txr, 0);
        if (v.gap > 0) begin
            chk("stall_scl_low_ready", stall_bad, 0);
            chk("stall_seen", stall_cnt, v.gap);
        end
        for (int b = 0; b < v.exp_bytes && b < 16; b++) begin
            if (v.rw) begin
                chk("rx_byte", rx_log[b], v.data[8 * (b % 4) +: 8]);
                chk("mack_bit", bus_bits[17 + 9 * b], (b == int'(v.len) - 1));
            end else begin
                dbyte = '0;
                for (int k = 0; k < 8; k++) dbyte = {dbyte[6:0], bus_bits[9 + 9 * b + k]};
                chk("tx_byte_on_bus", dbyte, v.data[8 * (b % 4) +: 8]);
            end
        end
        if (v.busy_at != 0) begin
            idle_bad = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (scl_o !== 1'b1 || ready !== 1'b1) idle_bad = 1'b1;
            end
            chk("busy_start_ignored", {idle_bad, 32'(n_start - s0)}, {1'b0, 32'd1});
        end
        $display("txn %0d rw=%0d addr=%h len=%0d cycles=%0d nack=%0d bytes=%0d",
                 idx, v.rw, v.addr, v.len, n, nack, moved);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rw addr    len    data          ackA ackD  gap busy cyc  nack bytes
        vecs[0] = '{1'b0, 7'h50, 4'd1,  32'h000000A5, 1'b0, 4'h0, 0,  0,  320,  1'b0, 1};
        vecs[1] = '{1'b1, 7'h3C, 4'd2,  32'h0000F012, 1'b0, 4'h0, 0,  0,  464,  1'b0, 2};
        vecs[2] = '{1'b0, 7'h21, 4'd3,  32'h00030201, 1'b1, 4'h0, 0,  0,  176,  1'b1, 0};
        vecs[3] = '{1'b0, 7'h6B, 4'd2,  32'h0000C33C, 1'b0, 4'h2, 50, 0,  513,  1'b1, 2};
        vecs[4] = '{1'b0, 7'h2A, 4'd0,  32'h00000000, 1'b0, 4'h0, 0,  30, 176,  1'b0, 0};
        vecs[5] = '{1'b1, 7'h7F, 4'd1,  32'h0000005A, 1'b0, 4'h0, 0,  0,  320,  1'b0, 1};
        vecs[6] = '{1'b0, 7'h01, 4'd15, 32'hC30180FF, 1'b0, 4'h0, 0,  0,  2336, 1'b0, 15};
        vecs[7] = '{1'b0, 7'h55, 4'd2,  32'h0000E10F, 1'b0, 4'h0, 0,  0,  464,  1'b0, 2};

        arst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; len = '0;
        tx_data = '0; tx_valid = 1'b0;
        cur_len = '0; cur_data = '0; cur_ack_addr = 1'b0; cur_ack_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lines", {scl_o, sda_o, ready, tx_ready, rx_valid, done, nack}, 7'b1110000);
        chk("reset_rx_data", rx_data, 8'h00);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a write data byte, then a clean transaction.
        cur_len = 4'd2; cur_data = 32'h0000E10F; cur_ack_addr = 1'b0; cur_ack_data = '0;
        @(negedge clk);
        rw = 1'b0; addr = 7'h55; len = 4'd2; tx_data = 8'h0F; tx_valid = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(negedge clk);
        chk("busy_before_reset", ready, 0);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_mid_write", {scl_o, sda_o, ready, nack, tx_ready, done, rx_valid}, 7'b1110000);
        @(negedge clk);
        arst_n = 1'b1;
        tx_valid = 1'b0;
        $display("txn reset mid-write applied");
        run_vec(7, vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
